// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular FIFO of fetched instructions between fetch and decode.
// Optional same-cycle empty-queue bypass is enabled by defining IFQ_BYPASS_EN.
module inst_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_branch,
  input  logic [31:0]              in_branch_addr,
  input  logic [3:0]               in_except,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_branch,
  output logic [31:0]              out_branch_addr,
  output logic [3:0]               out_except,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        branch;
    logic [31:0] branch_addr;
    logic [3:0]  except;
  } entry_t;

  entry_t      mem [DEPTH];
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        bypass;
  logic        wr_en;
  logic        rd_adv;
  entry_t      in_entry;
  entry_t      head;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  assign in_entry = '{pc: in_pc, inst: in_inst, branch: in_branch,
                      branch_addr: in_branch_addr, except: in_except};

`ifdef IFQ_BYPASS_EN
  assign bypass = empty && in_valid && !flush && !rst;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready  = !rst && !flush && !full;
  assign out_valid = !rst && !flush && (!empty || bypass);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A bypassed entry that decode takes immediately never touches the array.
  assign wr_en  = push && !(bypass && out_ready);
  assign rd_adv = pop && !bypass;

  always_comb begin
    head = '0;
    if (out_valid) begin
      head = bypass ? in_entry : mem[rd_ptr[AW-1:0]];
    end
  end

  assign out_pc          = head.pc;
  assign out_inst        = head.inst;
  assign out_branch      = head.branch;
  assign out_branch_addr = head.branch_addr;
  assign out_except      = head.except;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= in_entry;
    end
  end

  // Flush and reset both rewind the pointers; array contents are left stale.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized scoreboard bench for inst_fetch_queue; a queue-based model predicts
// acceptance and ordering, and a negedge monitor checks every handshake.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        branch;
    logic [31:0] branch_addr;
    logic [3:0]  except;
  } tb_entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_branch = 1'b0;
  logic [31:0] in_branch_addr = '0;
  logic [3:0]  in_except = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_branch;
  logic [31:0] out_branch_addr;
  logic [3:0]  out_except;
  logic [$clog2(DEPTH):0] count;

  tb_entry_t sb[$];
  int  checks = 0;
  int  failures = 0;
  bit  chk_en = 1'b0;
  logic        exp_in_ready;
  logic        exp_out_valid;
  logic [31:0] exp_count;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_branch(in_branch),
    .in_branch_addr(in_branch_addr), .in_except(in_except),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_branch(out_branch),
    .out_branch_addr(out_branch_addr), .out_except(out_except),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and predict what the queue must show this cycle.
  task automatic applyStimulus(input logic r, input logic f, input logic v, input logic rdy,
                               input logic [31:0] pc, input logic [31:0] inst,
                               input logic br, input logic [31:0] baddr, input logic [3:0] exc);
    tb_entry_t e;
    bit accept;
    @(posedge clk);
    #1;
    rst = r; flush = f; in_valid = v; out_ready = rdy;
    in_pc = pc; in_inst = inst; in_branch = br; in_branch_addr = baddr; in_except = exc;
    exp_count     = sb.size();
    exp_in_ready  = !r && !f && (sb.size() < DEPTH);
    exp_out_valid = !r && !f && ((sb.size() > 0) || (BYP && v));
    accept = !r && !f && v && (sb.size() < DEPTH);
    if (r || f) begin
      sb.delete();
    end else if (accept) begin
      e.pc = pc; e.inst = inst; e.branch = br; e.branch_addr = baddr; e.except = exc;
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput();
    tb_entry_t e;
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready});
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_out_valid});
    chk("count", 32'(count), exp_count);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("pop_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_inst", out_inst, e.inst);
        chk("out_branch", {31'b0, out_branch}, {31'b0, e.branch});
        chk("out_branch_addr", out_branch_addr, e.branch_addr);
        chk("out_except", {28'b0, out_except}, {28'b0, e.except});
      end
    end else if (!out_valid) begin
      chk("idle_data_zero", out_pc | out_inst | out_branch_addr | {27'b0, out_branch, out_except}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) checkOutput();
  end

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, rdy, '0, '0, 0, '0, '0);
  endtask

  task automatic pushPc(input logic rdy, input logic [31:0] pc, input logic [3:0] exc);
    applyStimulus(0, 0, 1, rdy, pc, pc ^ 32'h0280_0000, pc[2], pc + 32'h40, exc);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    exp_count = 0; exp_in_ready = 0; exp_out_valid = 0;
    applyStimulus(1, 0, 0, 0, '0, '0, 0, '0, '0);
    chk_en = 1'b1;
    applyStimulus(1, 0, 1, 1, 32'h1234, '0, 0, '0, '0);

    // Fill to DEPTH, hold while full, then drain in order.
    for (int i = 0; i < 4; i++) pushPc(0, 32'h1c00_0000 + 32'(4*i), 4'h0);
    idle(0, 1);
    idle(1, 5);

    // Steady-state push and pop with two entries resident, wrapping the pointers.
    for (int i = 0; i < 2; i++) pushPc(0, 32'h1c00_0200 + 32'(4*i), 4'h0);
    for (int i = 0; i < 10; i++) pushPc(1, 32'h1c00_0300 + 32'(4*i), 4'h0);
    idle(1, 3);

    // A full queue refuses a push even when popped in the same cycle.
    for (int i = 0; i < 4; i++) pushPc(0, 32'h1c00_0400 + 32'(4*i), 4'h0);
    pushPc(1, 32'h1c00_0500, 4'h0);
    idle(0, 1);
    idle(1, 4);

    // Flush with three entries resident and a new fetch offered.
    for (int i = 0; i < 3; i++) pushPc(0, 32'h1c00_0600 + 32'(4*i), 4'h0);
    applyStimulus(0, 1, 1, 1, 32'h1c00_0100, 32'h1c00_0100, 0, '0, '0);
    idle(0, 1);
    idle(1, 1);

    // Exception code rides with its instruction.
    pushPc(0, 32'h1c00_0002, 4'b0001);
    idle(1, 2);

    // Empty-queue offer with decode ready: same cycle only when bypass is built in.
    applyStimulus(0, 0, 1, 1, 32'h1c00_0700, 32'h0280_0000, 0, '0, '0);
    idle(1, 2);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 3),
                    ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 55),
                    $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom));
    end
    idle(1, 6);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch queue between the instruction-fetch stage and the decode stage. Accepts one fetched instruction per cycle, together with its PC, branch-prediction tag and fetch exception code, and buffers it in a circular FIFO. Decode drains the FIFO one entry per cycle under a valid/ready handshake. The block decouples fetch from decode stalls and discards all in-flight instructions on a pipeline flush.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries (branch mispredict / exception)
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept this cycle
- in_pc  in  32  instruction PC
- in_inst  in  32  instruction word
- in_branch  in  1  predicted taken
- in_branch_addr  in  32  predicted target
- in_except  in  4  {ppi, pif, tlbr, adef}
- out_valid  out  1  head entry valid for decode
- out_ready  in  1  decode accepts head
- out_pc, out_inst, out_branch_addr  out  32 each  head fields
- out_branch  out  1  head field
- out_except  out  4  head field
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: DEPTH-entry array of {pc, inst, branch, branch_addr, except}; rd_ptr/wr_ptr are $clog2(DEPTH)+1 bits wide, with the MSB used as the wrap bit.
- empty = (rd_ptr == wr_ptr). full = indices equal and wrap bits differ. count = wr_ptr − rd_ptr, mod 2^(width).
- push = in_valid && in_ready. pop = out_valid && out_ready.
- in_ready = !rst && !flush && !full. in_ready does not depend on out_ready; a full queue never accepts, even when popped in the same cycle.
- out_valid = !empty && !flush (bypass case below). When out_valid = 0, all out_* data fields are 0.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- Entries with nonzero in_except are queued like any other entry; the exception code travels with the instruction.
- flush: push and pop are both suppressed. Next cycle rd_ptr = wr_ptr = 0, count = 0. Array contents are not cleared.
- Pointers wrap from DEPTH−1 to 0 and toggle the wrap bit.

## Timing
- Reset: rd_ptr = wr_ptr = 0, count = 0, out_valid = 0, in_ready = 0 while rst is high, all out_* data = 0.
- Latency without bypass: a push at cycle N is visible at the head at N+1 if the queue was empty.
- Throughput: 1 push and 1 pop per cycle.
- flush asserted at cycle N: out_valid = 0 and in_ready = 0 during N. The queue is empty at N+1, and in_ready = 1 at N+1 if flush has dropped.
- rst mid-operation behaves as flush plus reset values.
- out_* come from a combinational array read at rd_ptr and are stable while out_valid && !out_ready.

## Configuration
- IFQ_BYPASS_EN defined:
  - When empty && in_valid && !flush: out_valid = 1 and out_* = in_* in the same cycle.
  - If out_ready is also high, the entry is consumed without a write and the pointers do not move.
  - If out_ready is low, the entry is written normally.
- IFQ_BYPASS_EN undefined: no bypass; empty-queue latency is 1 cycle.

## Test plan
- Fill/drain:
  - Stimulus: DEPTH = 4, out_ready = 0, push PCs 0x1c000000..0x1c00000c.
  - Response: count = 4 and in_ready = 0 after the 4th push. Then out_ready = 1 pops the same PCs in order, one per cycle; count reaches 0 and out_valid drops.
- Simultaneous push/pop:
  - Stimulus: count = 2, in_valid = out_ready = 1 for 10 cycles.
  - Response: count stays at 2, pointers wrap past index 3, and output order matches input order.
- Full with pop:
  - Stimulus: count = 4, out_ready = 1, in_valid = 1.
  - Response: pop occurs, in_ready = 0 (no push), count = 3 next cycle.
- Flush mid-stream:
  - Stimulus: count = 3, flush = 1 for one cycle, in_valid = 1 with pc 0x1c000100 during that cycle.
  - Response: out_valid = 0 and in_ready = 0 during flush. Next cycle count = 0 and 0x1c000100 was not stored.
- Exception carry:
  - Stimulus: push in_except = 4'b0001, in_pc = 0x1c000002.
  - Response: head shows out_except = 4'b0001 with out_pc = 0x1c000002.
- Bypass (IFQ_BYPASS_EN):
  - Stimulus: empty queue, in_valid = out_ready = 1, in_inst = 0x02800000.
  - Response: out_valid = 1 and out_inst = 0x02800000 in the same cycle; count remains 0. Without the macro, the entry appears one cycle later.
